// File: rtl/scm_pkg.sv
// scm_pkg: shared types and depth helper for the SCM LUT store and its stream loader
package scm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } loader_state_e;

    function automatic int depth(input int c, input int k);
        return c * k;
    endfunction

endpackage

// File: rtl/scm_stream_loader.sv
// scm_stream_loader: turns a valid/ready stream of LUT entries into paced SCM write pulses
module scm_stream_loader
    import scm_pkg::*;
#(
    parameter int C             = 32,
    parameter int K             = 16,
    parameter int DataTypeWidth = 16,
    parameter int WriteGap      = 1,
    localparam int TotalAddrWidth = $clog2(depth(C, K))
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [TotalAddrWidth-1:0]       base_addr_i,
    input  logic [TotalAddrWidth:0]         count_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic signed [DataTypeWidth-1:0] in_data_i,
    output logic [TotalAddrWidth-1:0]       waddr_o,
    output logic signed [DataTypeWidth-1:0] wdata_o,
    output logic                            we_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int Depth    = depth(C, K);
    localparam int GapWidth = WriteGap > 1 ? $clog2(WriteGap) : 1;
    localparam logic [GapWidth-1:0]         GapLoad    = GapWidth'(WriteGap > 0 ? WriteGap - 1 : 0);
    localparam logic [TotalAddrWidth:0]     DepthCount = (TotalAddrWidth + 1)'(Depth);
    localparam logic [TotalAddrWidth:0]     OneLeft    = (TotalAddrWidth + 1)'(1);
    localparam logic [TotalAddrWidth-1:0]   LastAddr   = TotalAddrWidth'(Depth - 1);

    loader_state_e             state_q, state_d;
    logic [TotalAddrWidth-1:0] addr_q;
    logic [TotalAddrWidth:0]   remaining_q;
    logic [GapWidth-1:0]       gap_q;
    logic                      beat;
    logic                      launch;

    // An accepted beat is dropped when abort arrives in the same cycle
    assign beat   = state_q == LOAD && in_valid_i && in_ready_o && !abort_i;
    assign launch = state_q == IDLE && start_i && count_i != '0 && count_i <= DepthCount;

    // Next-state selection; abort overrides a final beat
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = count_i == '0 ? DONE : count_i <= DepthCount ? LOAD : IDLE;
            LOAD:    if (abort_i) state_d = IDLE;
                     else if (beat) state_d = remaining_q == OneLeft ? DONE : WriteGap > 0 ? GAP : LOAD;
            GAP:     state_d = abort_i ? IDLE : gap_q == '0 ? LOAD : GAP;
            default: state_d = IDLE;
        endcase
    end

    // State and status outputs; ready/busy are registered images of the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_o <= state_d == LOAD;
            busy_o     <= state_d == LOAD || state_d == GAP;
            done_o     <= state_q == DONE;
            if (state_q == IDLE && start_i) err_o <= count_i > DepthCount;
        end
    end

    // Write datapath: address/count bookkeeping and the one-cycle write pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            gap_q       <= '0;
            we_o        <= 1'b0;
            waddr_o     <= '0;
            wdata_o     <= '0;
        end else begin
            we_o <= beat;
            if (launch) begin
                addr_q      <= base_addr_i;
                remaining_q <= count_i;
            end
            if (beat) begin
                waddr_o     <= addr_q;
                wdata_o     <= in_data_i;
                addr_q      <= addr_q == LastAddr ? '0 : addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                gap_q       <= GapLoad;
            end else if (state_q == GAP && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

endmodule
